modmul_barrett_pipe: RTL and testbench

//  Pipelined, multi-lane modular multiply-accumulate: r = (a*b + c) mod Q per lane.

---
 rtl/modmul_barrett_pipe_pkg.sv | 22 ++
 rtl/barrett_lane.sv | 52 +++++
 rtl/modmul_barrett_pipe.sv | 69 ++++++
 tb/tb_modmul_barrett_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/modmul_barrett_pipe_pkg.sv
// modmul_barrett_pipe_pkg: shared constants and Barrett parameter helpers
package modmul_barrett_pipe_pkg;
    localparam int Q_KYBER = 3329;
    localparam int W_KYBER = 12;

    function automatic int clog2(input longint unsigned v);
        int r = 0;
        longint unsigned p = 1;
        while (p < v) begin
            p = p << 1;
            r++;
        end
        return r;
    endfunction

    function automatic longint unsigned barrett_mu(input int q);
        return (64'd1 << (2 * clog2(longint'(q)))) / longint'(q);
    endfunction

    localparam int K = clog2(longint'(Q_KYBER));
    localparam longint unsigned MU = barrett_mu(Q_KYBER);
endpackage

// File: rtl/barrett_lane.sv
// barrett_lane: three-stage (a*b+c) mod Q datapath for one lane, advancing on en_i
module barrett_lane
    import modmul_barrett_pipe_pkg::*;
#(
    parameter int W = W_KYBER,
    parameter int Q = Q_KYBER
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         acc_en_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] r_o
);
    localparam int KQ = clog2(longint'(Q));
    localparam int MW = KQ + 1;
    localparam int XW = 2 * W + 1;
    localparam int PW = XW + MW;
    // Remainder after Barrett estimate is below 3Q < 2**(W+2) for in-range operands
    localparam int TW = W + 2;
    localparam logic [MW-1:0] MU_V = MW'(barrett_mu(Q));
    localparam logic [TW-1:0] QT = TW'(Q);

    logic [XW-1:0] x_q1;
    logic [TW-1:0] x_q2, qhat_q2;
    logic [TW-1:0] t0, t1;
    logic [W-1:0]  r_d, r_q;

    always_comb begin
        t0  = x_q2 - qhat_q2 * QT;
        t1  = (t0 >= QT) ? t0 - QT : t0;
        r_d = W'((t1 >= QT) ? t1 - QT : t1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q1    <= '0;
            x_q2    <= '0;
            qhat_q2 <= '0;
            r_q     <= '0;
        end else if (en_i) begin
            x_q1    <= XW'(a_i) * XW'(b_i) + XW'(acc_en_i ? c_i : '0);
            qhat_q2 <= TW'((PW'(x_q1) * PW'(MU_V)) >> (2 * KQ));
            x_q2    <= TW'(x_q1);
            r_q     <= r_d;
        end
    end

    assign r_o = r_q;
endmodule

// File: rtl/modmul_barrett_pipe.sv
// modmul_barrett_pipe: multi-lane pipelined (a*b+c) mod Q with valid/ready and tag sideband
module modmul_barrett_pipe
    import modmul_barrett_pipe_pkg::*;
#(
    parameter int W     = W_KYBER,
    parameter int Q     = Q_KYBER,
    parameter int LANES = 1,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               acc_en,
    input  logic [LANES*W-1:0] a_i,
    input  logic [LANES*W-1:0] b_i,
    input  logic [LANES*W-1:0] c_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] r_o,
    output logic [TAG_W-1:0]   tag_o
);
    if (longint'(Q) >= (longint'(1) << W) || (Q % 2) == 0 || Q <= 2) begin : g_bad_q
        $error("modmul_barrett_pipe: Q must be odd with 2 < Q < 2**W");
    end

    logic             en;
    logic             v1_q, v2_q, v3_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

    // The whole pipe stalls only when a finished result is not taken
    assign en       = !v3_q || out_ready;
    assign in_ready = en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
        end else if (en) begin
            v1_q   <= in_valid;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            tag1_q <= tag_i;
            tag2_q <= tag1_q;
            tag3_q <= tag2_q;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        barrett_lane #(.W(W), .Q(Q)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_i     (en),
            .acc_en_i (acc_en),
            .a_i      (a_i[l*W +: W]),
            .b_i      (b_i[l*W +: W]),
            .c_i      (c_i[l*W +: W]),
            .r_o      (r_o[l*W +: W])
        );
    end

    assign out_valid = v3_q;
    assign tag_o     = tag3_q;
endmodule

// File: tb/tb_modmul_barrett_pipe.sv
// tb_modmul_barrett_pipe: Kyber single-lane directed/stream tests plus 4-lane Q=65521 random regression
module tb_modmul_barrett_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    logic        k_in_valid, k_in_ready, k_acc, k_out_valid, k_out_ready;
    logic [11:0] k_a, k_b, k_c, k_r;
    logic [3:0]  k_tag, k_tag_o;

    logic        w_in_valid, w_in_ready, w_acc, w_out_valid, w_out_ready;
    logic [63:0] w_a, w_b, w_c, w_r;
    logic [7:0]  w_tag, w_tag_o;

    modmul_barrett_pipe #(.W(12), .Q(3329), .LANES(1), .TAG_W(4)) dut_k (
        .clk(clk), .rst_n(rst_n), .in_valid(k_in_valid), .in_ready(k_in_ready),
        .acc_en(k_acc), .a_i(k_a), .b_i(k_b), .c_i(k_c), .tag_i(k_tag),
        .out_valid(k_out_valid), .out_ready(k_out_ready), .r_o(k_r), .tag_o(k_tag_o)
    );

    modmul_barrett_pipe #(.W(16), .Q(65521), .LANES(4), .TAG_W(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .acc_en(w_acc), .a_i(w_a), .b_i(w_b), .c_i(w_c), .tag_i(w_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .r_o(w_r), .tag_o(w_tag_o)
    );

    function automatic logic [11:0] kref(input logic [11:0] a, b, c, input logic acc);
        longint unsigned p = longint'(a) * longint'(b) + (acc ? longint'(c) : 64'd0);
        return 12'(p % 3329);
    endfunction

    function automatic logic [15:0] wref(input logic [15:0] a, b, c, input logic acc);
        longint unsigned p = longint'(a) * longint'(b) + (acc ? longint'(c) : 64'd0);
        return 16'(p % 65521);
    endfunction

    function automatic logic [15:0] wrand();
        return ($urandom_range(0, 7) == 0) ? 16'd65520 : 16'($urandom_range(0, 65520));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        k_in_valid = 0; k_acc = 0; k_a = 0; k_b = 0; k_c = 0; k_tag = 0; k_out_ready = 1;
        w_in_valid = 0; w_acc = 0; w_a = 0; w_b = 0; w_c = 0; w_tag = 0; w_out_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (k_out_valid !== 1'b0) begin fails++; $display("FAIL reset_k_out_valid got=%b exp=0", k_out_valid); end
        checks++; if (k_r !== 12'd0) begin fails++; $display("FAIL reset_k_r got=%0d exp=0", k_r); end
        checks++; if (k_tag_o !== 4'd0) begin fails++; $display("FAIL reset_k_tag got=%0d exp=0", k_tag_o); end
        checks++; if (k_in_ready !== 1'b1) begin fails++; $display("FAIL reset_k_in_ready got=%b exp=1", k_in_ready); end
        checks++; if (w_out_valid !== 1'b0) begin fails++; $display("FAIL reset_w_out_valid got=%b exp=0", w_out_valid); end
        checks++; if (w_r !== 64'd0) begin fails++; $display("FAIL reset_w_r got=%h exp=0", w_r); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed(input string nm, input logic [11:0] a, b, c, input logic acc,
                                 input logic [3:0] tag, input logic [11:0] exp);
        @(negedge clk);
        k_in_valid = 1; k_a = a; k_b = b; k_c = c; k_acc = acc; k_tag = tag; k_out_ready = 1;
        #1;
        checks++; if (k_in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready got=%b exp=1", nm, k_in_ready); end
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            k_in_valid = 0;
            #1;
            checks++;
            if (k_out_valid !== (e == 3)) begin
                fails++; $display("FAIL %s_latency edge=%0d out_valid got=%b exp=%b", nm, e, k_out_valid, e == 3);
            end
        end
        checks++; if (k_r !== exp) begin fails++; $display("FAIL %s_r got=%0d exp=%0d", nm, k_r, exp); end
        checks++; if (k_tag_o !== tag) begin fails++; $display("FAIL %s_tag got=%0d exp=%0d", nm, k_tag_o, tag); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ba[20], bb[20], bc[20];
        logic        bacc[20];
        logic [15:0] q[$];
        logic [15:0] prev = '0;
        logic        held = 0;
        int sent = 0, got = 0;
        for (int i = 0; i < 20; i++) begin
            ba[i] = 12'($urandom_range(0, 3328));
            bb[i] = 12'($urandom_range(0, 3328));
            bc[i] = 12'($urandom_range(0, 3328));
            bacc[i] = 1'($urandom_range(0, 1));
        end
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            @(negedge clk);
            k_in_valid = (sent < 20);
            if (sent < 20) begin
                k_a = ba[sent]; k_b = bb[sent]; k_c = bc[sent]; k_acc = bacc[sent]; k_tag = 4'(sent);
            end
            k_out_ready = !(cyc >= 8 && cyc < 13);
            #1;
            if (!k_out_ready && k_out_valid) begin
                checks++; if (k_in_ready !== 1'b0) begin fails++; $display("FAIL b2b_stall_in_ready cyc=%0d got=%b exp=0", cyc, k_in_ready); end
                if (held) begin
                    checks++;
                    if ({k_tag_o, k_r} !== prev) begin fails++; $display("FAIL b2b_stall_stable cyc=%0d got=%h exp=%h", cyc, {k_tag_o, k_r}, prev); end
                end
                prev = {k_tag_o, k_r};
                held = 1;
            end else held = 0;
            if (k_out_valid && k_out_ready) begin
                checks++;
                if (q.size() == 0 || {k_tag_o, k_r} !== q[0]) begin
                    fails++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", got, {k_tag_o, k_r}, (q.size() != 0) ? q[0] : 16'hxxxx);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            if (k_in_valid && k_in_ready) begin
                q.push_back({4'(sent), kref(ba[sent], bb[sent], bc[sent], bacc[sent])});
                sent++;
            end
        end
        k_in_valid = 0; k_out_ready = 1;
        checks++;
        if (got != 20 || q.size() != 0) begin fails++; $display("FAIL b2b_count got=%0d exp=20 leftover=%0d", got, q.size()); end
    endtask

    task automatic test_reset_midflight();
        logic [11:0] e;
        int seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            k_in_valid = 1; k_a = 12'(5 + i); k_b = 12'd7; k_c = 0; k_acc = 0; k_tag = 4'(i + 1); k_out_ready = 1;
        end
        @(negedge clk);
        k_in_valid = 0;
        rst_n = 1'b0;
        #1;
        checks++; if (k_out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got=%b exp=0", k_out_valid); end
        checks++; if (k_r !== 12'd0) begin fails++; $display("FAIL midrst_r got=%0d exp=0", k_r); end
        checks++; if (k_tag_o !== 4'd0) begin fails++; $display("FAIL midrst_tag got=%0d exp=0", k_tag_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        k_in_valid = 1; k_a = 12'd100; k_b = 12'd200; k_c = 12'd17; k_acc = 1; k_tag = 4'd9;
        e = kref(12'd100, 12'd200, 12'd17, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            k_in_valid = 0;
            #1;
            if (k_out_valid) begin
                seen++;
                checks++;
                if ({k_tag_o, k_r} !== {4'd9, e}) begin fails++; $display("FAIL midrst_new_beat got=%h exp=%h", {k_tag_o, k_r}, {4'd9, e}); end
            end
        end
        checks++; if (seen != 1) begin fails++; $display("FAIL midrst_emerged got=%0d exp=1", seen); end
    endtask

    task automatic test_random_wide();
        localparam int N = 3000;
        logic [71:0] q[$];
        logic [71:0] exp;
        logic [63:0] pa = '0, pb = '0, pc = '0;
        logic        pacc = 0;
        logic [7:0]  ptag = '0;
        logic        pend = 0;
        int sent = 0, got = 0;
        for (int cyc = 0; cyc < 40000 && got < N; cyc++) begin
            @(negedge clk);
            if (!pend && sent < N && $urandom_range(0, 3) != 0) begin
                for (int l = 0; l < 4; l++) begin
                    pa[l*16 +: 16] = wrand(); pb[l*16 +: 16] = wrand(); pc[l*16 +: 16] = wrand();
                end
                pacc = 1'($urandom_range(0, 1));
                ptag = 8'($urandom);
                pend = 1;
            end
            w_in_valid = pend; w_a = pa; w_b = pb; w_c = pc; w_acc = pacc; w_tag = ptag;
            w_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (w_in_ready !== (!w_out_valid || w_out_ready)) begin
                fails++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, w_in_ready, !w_out_valid || w_out_ready);
            end
            if (w_out_valid && w_out_ready) begin
                checks++;
                if (q.size() == 0 || {w_tag_o, w_r} !== q[0]) begin
                    fails++; $display("FAIL rnd_result idx=%0d got=%h exp=%h", got, {w_tag_o, w_r}, (q.size() != 0) ? q[0] : 72'hx);
                end
                for (int l = 0; l < 4; l++) begin
                    checks++;
                    if (!(w_r[l*16 +: 16] < 16'd65521)) begin fails++; $display("FAIL rnd_range lane=%0d got=%0d exp=<65521", l, w_r[l*16 +: 16]); end
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            if (w_in_valid && w_in_ready) begin
                exp[71:64] = ptag;
                for (int l = 0; l < 4; l++) exp[l*16 +: 16] = wref(pa[l*16 +: 16], pb[l*16 +: 16], pc[l*16 +: 16], pacc);
                q.push_back(exp);
                pend = 0;
                sent++;
            end
        end
        w_in_valid = 0; w_out_ready = 1;
        checks++;
        if (got != N || q.size() != 0) begin fails++; $display("FAIL rnd_count got=%0d exp=%0d leftover=%0d", got, N, q.size()); end
    endtask

    initial begin
        test_reset();
        test_directed("basic", 12'd1234, 12'd2345, 12'd0, 1'b0, 4'hA, 12'd829);
        test_directed("max_sq", 12'd3328, 12'd3328, 12'd0, 1'b0, 4'h3, 12'd1);
        test_directed("wrap_q", 12'd3328, 12'd3328, 12'd3328, 1'b1, 4'h5, 12'd0);
        test_directed("no_oversub", 12'd0, 12'd0, 12'd3328, 1'b1, 4'hF, 12'd3328);
        test_back_to_back();
        test_reset_midflight();
        test_random_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
